regfile_write_arbiter: RTL

Shares the single write port of `register_file` between two requesters:

- **Core writeback path (wb):** the single-cycle datapath. It has absolute priority and is never back-pressured.
- **Auxiliary requester (aux):** e.g. a multi-cycle divider or debug unit. It uses a valid/ready handshake and is buffered in a FIFO_DEPTH-entry FIFO.

The arbiter drives `reg_write_enable`/`rd_addr`/`write_data` of the register file. It exports a pending-write bitmap so the core can interlock on registers still queued, and a stall request when aux writes are starving.

---
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the core writeback path (absolute
// priority) and a FIFO-buffered auxiliary requester with starvation signalling.
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH     = 4,
    parameter int STARVE_LIMIT   = 4,
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      aux_valid,
    output logic                      aux_ready,
    input  logic [REG_ADDR_WIDTH-1:0] aux_rd_addr,
    input  logic [XLEN-1:0]           aux_data,
    output logic                      reg_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]           write_data,
    output logic [31:0]               pending_mask,
    output logic                      stall_req
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [REG_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [XLEN-1:0]           fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic [STARVE_W-1:0]       starve_cnt;
    logic [STARVE_W-1:0]       starve_next;
    logic                      fifo_empty;
    logic                      wb_eff;
    logic                      enq;
    logic                      deq;

    assign fifo_empty = (count == '0);
    assign aux_ready  = (count != FULL_COUNT);
    assign wb_eff     = wb_valid && (wb_rd_addr != '0);
    assign enq        = aux_valid && aux_ready && (aux_rd_addr != '0);
    assign deq        = !wb_eff && !fifo_empty;

    // Writes to x0 are architecturally dead, so they never claim the port.
    always_comb begin
        reg_write_enable = 1'b0;
        rd_addr          = '0;
        write_data       = '0;
        if (wb_eff) begin
            reg_write_enable = 1'b1;
            rd_addr          = wb_rd_addr;
            write_data       = wb_data;
        end else if (!fifo_empty) begin
            reg_write_enable = 1'b1;
            rd_addr          = fifo_addr[head];
            write_data       = fifo_data[head];
        end
    end

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase

        starve_next = '0;
        if (!fifo_empty && !deq) begin
            starve_next = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + STARVE_W'(1);
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin : pending_decode
        logic [PTR_W-1:0] offset;
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - head;
            if ({1'b0, offset} < count) begin
                pending_mask[fifo_addr[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[tail] <= aux_rd_addr;
            fifo_data[tail] <= aux_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count      <= count_next;
            starve_cnt <= starve_next;
            if (deq) begin
                stall_req <= 1'b0;
            end else if (starve_next == STARVE_MAX) begin
                stall_req <= 1'b1;
            end
        end
    end

endmodule
